nread_scheduler: RTL and testbench

- Arbitrates NREAD transfer descriptors from NUM_REQ requesters, such as the host register block and the DMA command path, onto the single nread_engine.
- Round-robin grant. Issues one start pulse per descriptor, then waits for the engine's finish pulse or a timeout.
- Returns a per-requester completion pulse with status.
- Sits between the srio_trc control/register logic and nread_engine. nread_engine is strictly one-transfer-at-a-time; this block enforces that.

---
 rtl/nread_sched_pkg.sv | 20 ++
 rtl/nread_scheduler_if.sv | 42 ++++
 rtl/rr_arbiter.sv | 36 +++
 rtl/nread_scheduler.sv | 150 +++++++++++++++
 tb/tb_nread_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nread_sched_pkg.sv
// nread_sched_pkg: shared constants and types for the NREAD descriptor scheduler.
//   state_e         - scheduler FSM states (IDLE, LAUNCH, WAIT, DONE)
//   TIMEOUT_CYC_DEF - default start-to-finish timeout in aclk cycles
//   ADDR_W/SIZE_W/DB_W - descriptor field widths
package nread_sched_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned SIZE_W = 16;
    localparam int unsigned DB_W   = 16;

    localparam logic [31:0] TIMEOUT_CYC_DEF = 32'd1048576;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/nread_scheduler_if.sv
// nread_scheduler_if: requester, engine and completion signals of the NREAD scheduler.
//   Requester side : req_valid, req_ready, req_src_addr, req_dst_addr, req_size_dw, req_db_info
//                    (requester i occupies slice [W*i +: W] of each packed descriptor bus)
//   Engine side    : eng_start, eng_src_addr, eng_dst_addr, eng_size_dw, eng_db_info, eng_finish
//   Completion     : done_valid (one-hot), done_err (1 = timeout)
// modport master is the scheduler; modport slave is the requesters/engine side.
interface nread_scheduler_if
    import nread_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_src_addr;
    logic [NUM_REQ*ADDR_W-1:0] req_dst_addr;
    logic [NUM_REQ*SIZE_W-1:0] req_size_dw;
    logic [NUM_REQ*DB_W-1:0]   req_db_info;

    logic                      eng_start;
    logic [ADDR_W-1:0]         eng_src_addr;
    logic [ADDR_W-1:0]         eng_dst_addr;
    logic [SIZE_W-1:0]         eng_size_dw;
    logic [DB_W-1:0]           eng_db_info;
    logic                      eng_finish;

    logic [NUM_REQ-1:0]        done_valid;
    logic                      done_err;

    modport master (
        input  req_valid, req_src_addr, req_dst_addr, req_size_dw, req_db_info, eng_finish,
        output req_ready, eng_start, eng_src_addr, eng_dst_addr, eng_size_dw, eng_db_info,
               done_valid, done_err
    );

    modport slave (
        output req_valid, req_src_addr, req_dst_addr, req_size_dw, req_db_info, eng_finish,
        input  req_ready, eng_start, eng_src_addr, eng_dst_addr, eng_size_dw, eng_db_info,
               done_valid, done_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req        in  NUM_REQ  request vector
//   last_grant in  RRW      previously granted index; search starts at last_grant+1
//   grant      out RRW      first requesting index found (0 when none)
//   any_req    out 1        at least one request present
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned RRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [RRW-1:0]     last_grant,
    output logic [RRW-1:0]     grant,
    output logic               any_req
);

    logic           found;
    int unsigned    idx;
    logic [RRW-1:0] idx_r;

    always_comb begin
        grant   = '0;
        any_req = |req;
        found   = 1'b0;
        idx     = 0;
        idx_r   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx   = (32'(last_grant) + k) % NUM_REQ;
            idx_r = RRW'(idx);
            if (!found && req[idx_r]) begin
                found = 1'b1;
                grant = idx_r;
            end
        end
    end

endmodule

// File: rtl/nread_scheduler.sv
// nread_scheduler: round-robin arbiter feeding NREAD descriptors to a single nread_engine,
// one transfer at a time, with finish/timeout supervision.
//   aclk, aresetn  clock and asynchronous active-low reset
//   enable         gate for new grants (an in-flight transfer always completes)
//   bus            nread_scheduler_if.master: requester, engine and completion signals
//   busy           high whenever the FSM is not IDLE
//   cur_grant      requester currently owning the engine
//   timeout_count  saturating count of timed-out transfers
//   stray_count    saturating count of eng_finish seen outside WAIT
module nread_scheduler
    import nread_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter logic [31:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int unsigned RRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                enable,
    nread_scheduler_if.master   bus,
    output logic                busy,
    output logic [RRW-1:0]      cur_grant,
    output logic [15:0]         timeout_count,
    output logic [15:0]         stray_count
);

    state_e             state_q, state_d;
    logic [RRW-1:0]     grant_q, grant_d;
    logic [RRW-1:0]     last_q, last_d;
    logic [ADDR_W-1:0]  src_q, src_d, dst_q, dst_d;
    logic [SIZE_W-1:0]  size_q, size_d;
    logic [DB_W-1:0]    db_q, db_d;
    logic               err_q, err_d;
    logic [31:0]        tmo_q, tmo_d;
    logic [15:0]        tcnt_q, tcnt_d, scnt_q, scnt_d;
    logic [RRW-1:0]     arb_grant;
    logic               arb_any;
    logic [NUM_REQ-1:0] grant_oh;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_q),
        .grant      (arb_grant),
        .any_req    (arb_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        src_d   = src_q;
        dst_d   = dst_q;
        size_d  = size_q;
        db_d    = db_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        tcnt_d  = tcnt_q;
        scnt_d  = scnt_q;
        unique case (state_q)
            IDLE: begin
                if (enable && arb_any) begin
                    grant_d = arb_grant;
                    last_d  = arb_grant;
                    // Capture the descriptor now so eng_* are stable before the start cycle.
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (arb_grant == RRW'(i)) begin
                            src_d  = bus.req_src_addr[i*ADDR_W +: ADDR_W];
                            dst_d  = bus.req_dst_addr[i*ADDR_W +: ADDR_W];
                            size_d = bus.req_size_dw[i*SIZE_W +: SIZE_W];
                            db_d   = bus.req_db_info[i*DB_W +: DB_W];
                        end
                    end
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A finish on the last allowed cycle still counts as success.
                if (bus.eng_finish) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (tmo_q == TIMEOUT_CYC - 32'd1) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                    if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.eng_finish && (state_q != WAIT) && (scnt_q != 16'hFFFF)) begin
            scnt_d = scnt_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= RRW'(NUM_REQ - 1);
            src_q   <= '0;
            dst_q   <= '0;
            size_q  <= '0;
            db_q    <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            tcnt_q  <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            size_q  <= size_d;
            db_q    <= db_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            tcnt_q  <= tcnt_d;
            scnt_q  <= scnt_d;
        end
    end

    // Outputs are decodes of registered state only; no input reaches an output directly.
    always_comb begin
        grant_oh       = NUM_REQ'(1) << grant_q;
        bus.eng_start  = (state_q == LAUNCH);
        bus.req_ready  = (state_q == LAUNCH) ? grant_oh : '0;
        bus.done_valid = (state_q == DONE) ? grant_oh : '0;
        bus.done_err   = (state_q == DONE) && err_q;
        bus.eng_src_addr = src_q;
        bus.eng_dst_addr = dst_q;
        bus.eng_size_dw  = size_q;
        bus.eng_db_info  = db_q;
        busy          = (state_q != IDLE);
        cur_grant     = grant_q;
        timeout_count = tcnt_q;
        stray_count   = scnt_q;
    end

endmodule

// File: tb/tb_nread_scheduler.sv
// Self-checking bench for nread_scheduler: directed scenarios plus a randomized phase checked
// against a transaction-level reference (round-robin pick from the valid vector, finish/timeout
// latency arithmetic).
module tb_nread_scheduler;
    import nread_sched_pkg::*;

    localparam int unsigned NR  = 2;
    localparam logic [31:0] TMO = 32'd100;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable  = 1'b0;
    logic        busy;
    logic [0:0]  cur_grant;
    logic [15:0] timeout_count;
    logic [15:0] stray_count;

    nread_scheduler_if #(.NUM_REQ(NR)) bus ();

    nread_scheduler #(
        .NUM_REQ     (NR),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .enable        (enable),
        .bus           (bus),
        .busy          (busy),
        .cur_grant     (cur_grant),
        .timeout_count (timeout_count),
        .stray_count   (stray_count)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [31:0] d_src  [NR];
    logic [31:0] d_dst  [NR];
    logic [15:0] d_size [NR];
    logic [15:0] d_db   [NR];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic set_desc(input int i, input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] size, input logic [15:0] db);
        d_src[i] = src;
        d_dst[i] = dst;
        d_size[i] = size;
        d_db[i] = db;
        bus.req_src_addr[i*32 +: 32] = src;
        bus.req_dst_addr[i*32 +: 32] = dst;
        bus.req_size_dw[i*16 +: 16]  = size;
        bus.req_db_info[i*16 +: 16]  = db;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        enable = 1'b0;
        bus.req_valid = '0;
        bus.eng_finish = 1'b0;
        repeat (3) step();
        aresetn = 1'b1;
        step();
    endtask

    task automatic wait_start(input string tag, input int budget);
        bit ok = 0;
        for (int n = 0; n < budget && !ok; n++) begin
            step();
            if (bus.eng_start) ok = 1;
        end
        check({tag, "_start_seen"}, 64'(ok), 64'd1);
    endtask

    function automatic int rr_pick(input int last, input logic [NR-1:0] v);
        for (int k = 1; k <= NR; k++) if (v[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    task automatic t_single();
        bit early;
        do_reset();
        check("rst_ctrl", {busy, bus.eng_start, bus.req_ready, bus.done_valid, bus.done_err,
                           cur_grant}, 0);
        check("rst_bus", {bus.eng_src_addr, bus.eng_size_dw, bus.eng_db_info}, 0);
        check("rst_cnt", {timeout_count, stray_count}, 0);
        enable = 1'b1;
        set_desc(0, 32'h1000_0000, 32'h8000_0000, 16'h003F, 16'h5A5A);
        bus.req_valid = 2'b01;
        wait_start("t1", 20);
        check("t1_src", bus.eng_src_addr, 32'h1000_0000);
        check("t1_dst", bus.eng_dst_addr, 32'h8000_0000);
        check("t1_size", bus.eng_size_dw, 16'h003F);
        check("t1_db", bus.eng_db_info, 16'h5A5A);
        check("t1_ready", bus.req_ready, 2'b01);
        bus.req_valid = '0;
        step();
        check("t1_start_one_cycle", bus.eng_start, 0);
        early = 0;
        repeat (49) begin
            step();
            if (bus.done_valid != 0) early = 1;
        end
        check("t1_no_early_done", early, 0);
        bus.eng_finish = 1'b1;
        step();
        bus.eng_finish = 1'b0;
        check("t1_done", bus.done_valid, 2'b01);
        check("t1_err", bus.done_err, 0);
        step();
        check("t1_busy_after", busy, 0);
    endtask

    task automatic t_round_robin();
        int last_s = 0;
        do_reset();
        enable = 1'b1;
        set_desc(0, 32'hA000_0000, 32'hB000_0000, 16'h0001, 16'h1111);
        set_desc(1, 32'hC000_0000, 32'hD000_0000, 16'h0002, 16'h2222);
        bus.req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_start("rr", 20);
            check("rr_ready", bus.req_ready, (t % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_grant", cur_grant, t % 2);
            check("rr_src", bus.eng_src_addr, d_src[t % 2]);
            if (t > 0) check("rr_gap", cyc - last_s, 4);
            last_s = cyc;
            step();
            bus.eng_finish = 1'b1;
            step();
            bus.eng_finish = 1'b0;
            check("rr_done", bus.done_valid, (t % 2 == 0) ? 2'b01 : 2'b10);
        end
        bus.req_valid = '0;
        step();
    endtask

    task automatic t_timeout();
        int n = 0;
        bit seen = 0;
        do_reset();
        enable = 1'b1;
        set_desc(0, 32'h1234_5678, 32'h9ABC_DEF0, 16'h0010, 16'h0BAD);
        bus.req_valid = 2'b01;
        wait_start("tmo", 20);
        bus.req_valid = '0;
        step();
        while (n < 200 && bus.done_valid == 0) begin
            step();
            n++;
        end
        check("tmo_delay", n, 100);
        check("tmo_done", bus.done_valid, 2'b01);
        check("tmo_err", bus.done_err, 1);
        check("tmo_count", timeout_count, 1);
        repeat (10) step();
        bus.eng_finish = 1'b1;
        step();
        bus.eng_finish = 1'b0;
        check("stray_count", stray_count, 1);
        repeat (5) begin
            if (bus.done_valid != 0 || busy) seen = 1;
            step();
        end
        check("stray_no_done", seen, 0);
        // Finish exactly on the last cycle before timeout.
        bus.req_valid = 2'b01;
        wait_start("edge", 20);
        bus.req_valid = '0;
        step();
        repeat (99) step();
        bus.eng_finish = 1'b1;
        step();
        bus.eng_finish = 1'b0;
        check("edge_done", bus.done_valid, 2'b01);
        check("edge_err", bus.done_err, 0);
        check("edge_tmo_count", timeout_count, 1);
    endtask

    task automatic t_enable();
        int starts = 0;
        do_reset();
        set_desc(0, 32'h0000_1000, 32'h0000_2000, 16'h0003, 16'h0A0A);
        set_desc(1, 32'h0000_3000, 32'h0000_4000, 16'h0004, 16'h0B0B);
        bus.req_valid = 2'b11;
        repeat (20) begin
            step();
            if (bus.eng_start) starts++;
        end
        check("en_off_nostart", starts, 0);
        check("en_off_idle", busy, 0);
        enable = 1'b1;
        wait_start("en", 20);
        check("en_first_grant", bus.req_ready, 2'b01);
        bus.req_valid = 2'b10;
        step();
        enable = 1'b0;
        repeat (5) step();
        bus.eng_finish = 1'b1;
        step();
        bus.eng_finish = 1'b0;
        check("en_drop_done", bus.done_valid, 2'b01);
        check("en_drop_err", bus.done_err, 0);
        starts = 0;
        repeat (10) begin
            step();
            if (bus.eng_start) starts++;
        end
        check("en_drop_nostart", starts, 0);
    endtask

    task automatic t_reset_mid();
        do_reset();
        enable = 1'b1;
        set_desc(0, 32'h5555_0000, 32'h6666_0000, 16'h0020, 16'h00FF);
        bus.req_valid = 2'b01;
        wait_start("rm", 20);
        bus.req_valid = '0;
        repeat (6) step();
        check("rm_busy_before", busy, 1);
        aresetn = 1'b0;
        step();
        check("rm_ctrl_zero", {busy, bus.eng_start, bus.req_ready, bus.done_valid,
                               bus.done_err, cur_grant}, 0);
        check("rm_bus_zero", {bus.eng_src_addr, bus.eng_dst_addr}, 0);
        step();
        check("rm_no_done", bus.done_valid, 0);
        aresetn = 1'b1;
        set_desc(1, 32'h7777_0000, 32'h8888_0000, 16'h0040, 16'h0F0F);
        bus.req_valid = 2'b10;
        wait_start("rm2", 20);
        check("rm2_ready", bus.req_ready, 2'b10);
        check("rm2_grant", cur_grant, 1);
        check("rm2_src", bus.eng_src_addr, 32'h7777_0000);
        check("rm2_db", bus.eng_db_info, 16'h0F0F);
        bus.req_valid = '0;
        step();
        bus.eng_finish = 1'b1;
        step();
        bus.eng_finish = 1'b0;
        check("rm2_done", bus.done_valid, 2'b10);
    endtask

    task automatic t_random();
        logic [NR-1:0] pend = '0;
        logic [NR-1:0] applied;
        logic [NR-1:0] oh;
        bit   applied_en;
        bit   exp_err = 0;
        int   model_last = NR - 1;
        int   starts = 0;
        int   tmo_model = 0;
        int   last_start = -100;
        int   fin_cyc = -1;
        int   exp_done = -1;
        int   g;
        do_reset();
        for (int c = 0; c < 20000 && starts < 40; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    set_desc(i, $urandom, $urandom, 16'($urandom), 16'($urandom));
                    pend[i] = 1'b1;
                end
            end
            bus.req_valid = pend;
            enable = ($urandom_range(0, 9) != 0);
            bus.eng_finish = (cyc == fin_cyc);
            applied = pend;
            applied_en = enable;
            step();
            if (bus.eng_start) begin
                check("rnd_start_allowed", 64'(applied_en && applied != 0), 1);
                check("rnd_gap_ok", 64'(cyc - last_start >= 4), 1);
                g = rr_pick(model_last, applied);
                oh = NR'(1) << g;
                check("rnd_ready", bus.req_ready, oh);
                check("rnd_grant", cur_grant, g);
                check("rnd_desc", {bus.eng_src_addr, bus.eng_dst_addr},
                      {d_src[g], d_dst[g]});
                check("rnd_desc2", {bus.eng_size_dw, bus.eng_db_info}, {d_size[g], d_db[g]});
                pend[g] = 1'b0;
                model_last = g;
                last_start = cyc;
                starts++;
                if ($urandom_range(0, 4) == 0) begin
                    fin_cyc = -1;
                    exp_done = cyc + 1 + int'(TMO);
                    exp_err = 1;
                end else begin
                    fin_cyc = cyc + 1 + int'($urandom_range(0, 99));
                    exp_done = fin_cyc + 1;
                    exp_err = 0;
                end
            end
            if (bus.done_valid != 0 || cyc == exp_done) begin
                oh = NR'(1) << model_last;
                if (cyc == exp_done && exp_err) tmo_model++;
                check("rnd_done", bus.done_valid, (cyc == exp_done) ? oh : '0);
                check("rnd_err", bus.done_err, exp_err);
                check("rnd_tmo_count", timeout_count, tmo_model);
            end
        end
        check("rnd_starts", starts, 40);
        check("rnd_stray", stray_count, 0);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_src_addr = '0;
        bus.req_dst_addr = '0;
        bus.req_size_dw = '0;
        bus.req_db_info = '0;
        bus.eng_finish = 1'b0;
        t_single();
        t_round_robin();
        t_timeout();
        t_enable();
        t_reset_mid();
        t_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion",
                 n_checks);
        $fatal(1);
    end

endmodule
